// File: rtl/regfile_pkg.sv
// Shared register-file types for the operand-fetch stage and its bypass slices.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_TAG_WIDTH  = 8;

    typedef logic [REG_DATA_WIDTH-1:0] regData_t;
    typedef logic [REG_ADDR_WIDTH-1:0] regAddr_t;
    typedef logic [REG_TAG_WIDTH-1:0]  regTag_t;

    localparam regAddr_t ZERO_REG_ADDR = '0;

    typedef struct packed {
        regAddr_t srcA;
        regAddr_t srcB;
        regTag_t  tag;
    } operandReq_t;

endpackage

// File: rtl/operand_bypass.sv
// One read-port slice: bank read-address mux, write-bypass capture and operand select.
// Latency: operand valid the cycle after the read address is driven.
// Backpressure: none; re-reads the held address every cycle the stage is not accepting.
module operand_bypass
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  accept,
    input  logic [ADDR_WIDTH-1:0] issueSrc,
    input  logic [ADDR_WIDTH-1:0] heldSrc,
    input  logic                  bankWriteEnable,
    input  logic [ADDR_WIDTH-1:0] bankWriteAddress,
    input  logic [DATA_WIDTH-1:0] wbData,
    input  logic [DATA_WIDTH-1:0] bankReadData,
    output logic [ADDR_WIDTH-1:0] readAddress,
    output logic [DATA_WIDTH-1:0] operand
);

    logic                  byp;
    logic [DATA_WIDTH-1:0] bypData;
    logic                  srcIsZero;

    assign readAddress = accept ? issueSrc : heldSrc;

    // The bank returns pre-write data for a same-cycle write, so remember that write here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byp     <= 1'b0;
            bypData <= '0;
        end else begin
            byp     <= bankWriteEnable && (bankWriteAddress == readAddress);
            bypData <= wbData;
        end
    end

    assign srcIsZero = ZERO_REG && (heldSrc == ADDR_WIDTH'(ZERO_REG_ADDR));

    always_comb begin
        operand = bankReadData;
        if (srcIsZero) begin
            operand = '0;
        end else if (byp) begin
            operand = bypData;
        end
    end

endmodule

// File: rtl/regfile_operand_fetch.sv
// Operand fetch in front of a dual-read-port register bank, with writeback bypass.
// Latency: request accepted in cycle T presents operands in T+1.
// Backpressure: one-deep; issueReady = !opValid || opReady, operands refreshed while stalled.
module regfile_operand_fetch
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = REG_DATA_WIDTH,
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
    parameter int TAG_WIDTH  = REG_TAG_WIDTH,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issueValid,
    output logic                  issueReady,
    input  logic [ADDR_WIDTH-1:0] issueSrcA,
    input  logic [ADDR_WIDTH-1:0] issueSrcB,
    input  logic [TAG_WIDTH-1:0]  issueTag,
    input  logic                  flush,
    input  logic                  wbValid,
    input  logic [ADDR_WIDTH-1:0] wbAddr,
    input  logic [DATA_WIDTH-1:0] wbData,
    output logic                  bankWriteEnable,
    output logic [ADDR_WIDTH-1:0] bankWriteAddress,
    output logic [DATA_WIDTH-1:0] bankWriteData,
    output logic [ADDR_WIDTH-1:0] bankReadAddressA,
    output logic [ADDR_WIDTH-1:0] bankReadAddressB,
    input  logic [DATA_WIDTH-1:0] bankReadDataA,
    input  logic [DATA_WIDTH-1:0] bankReadDataB,
    output logic                  opValid,
    input  logic                  opReady,
    output logic [DATA_WIDTH-1:0] opA,
    output logic [DATA_WIDTH-1:0] opB,
    output logic [TAG_WIDTH-1:0]  opTag
);

    logic        opValidQ;
    logic        accept;
    operandReq_t held;

    assign issueReady = !opValidQ || opReady;
    // Flush drops a same-cycle issue without touching issueReady.
    assign accept     = issueValid && issueReady && !flush;

    assign bankWriteEnable  = wbValid && !(ZERO_REG && (wbAddr == ADDR_WIDTH'(ZERO_REG_ADDR)));
    assign bankWriteAddress = wbAddr;
    assign bankWriteData    = wbData;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            opValidQ <= 1'b0;
            held     <= '0;
        end else begin
            if (flush) begin
                opValidQ <= 1'b0;
            end else if (accept) begin
                opValidQ <= 1'b1;
            end else if (opValidQ && opReady) begin
                opValidQ <= 1'b0;
            end
            if (accept) begin
                held.srcA <= regAddr_t'(issueSrcA);
                held.srcB <= regAddr_t'(issueSrcB);
                held.tag  <= regTag_t'(issueTag);
            end
        end
    end

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_a (
        .clk              (clk),
        .reset_n          (reset_n),
        .accept           (accept),
        .issueSrc         (issueSrcA),
        .heldSrc          (ADDR_WIDTH'(held.srcA)),
        .bankWriteEnable  (bankWriteEnable),
        .bankWriteAddress (bankWriteAddress),
        .wbData           (wbData),
        .bankReadData     (bankReadDataA),
        .readAddress      (bankReadAddressA),
        .operand          (opA)
    );

    operand_bypass #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG)
    ) u_port_b (
        .clk              (clk),
        .reset_n          (reset_n),
        .accept           (accept),
        .issueSrc         (issueSrcB),
        .heldSrc          (ADDR_WIDTH'(held.srcB)),
        .bankWriteEnable  (bankWriteEnable),
        .bankWriteAddress (bankWriteAddress),
        .wbData           (wbData),
        .bankReadData     (bankReadDataB),
        .readAddress      (bankReadAddressB),
        .operand          (opB)
    );

    assign opValid = opValidQ;
    assign opTag   = TAG_WIDTH'(held.tag);

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: behavioural bank, architectural register model, directed then random traffic.
module tb_regfile_operand_fetch;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int TW = 8;
    localparam int NREG = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          issueValid = 1'b0;
    logic          issueReady;
    logic [AW-1:0] issueSrcA = '0;
    logic [AW-1:0] issueSrcB = '0;
    logic [TW-1:0] issueTag = '0;
    logic          flush = 1'b0;
    logic          wbValid = 1'b0;
    logic [AW-1:0] wbAddr = '0;
    logic [DW-1:0] wbData = '0;
    logic          bankWriteEnable;
    logic [AW-1:0] bankWriteAddress;
    logic [DW-1:0] bankWriteData;
    logic [AW-1:0] bankReadAddressA;
    logic [AW-1:0] bankReadAddressB;
    logic [DW-1:0] bankReadDataA = '0;
    logic [DW-1:0] bankReadDataB = '0;
    logic          opValid;
    logic          opReady = 1'b1;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic [TW-1:0] opTag;

    regfile_operand_fetch dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .issueValid       (issueValid),
        .issueReady       (issueReady),
        .issueSrcA        (issueSrcA),
        .issueSrcB        (issueSrcB),
        .issueTag         (issueTag),
        .flush            (flush),
        .wbValid          (wbValid),
        .wbAddr           (wbAddr),
        .wbData           (wbData),
        .bankWriteEnable  (bankWriteEnable),
        .bankWriteAddress (bankWriteAddress),
        .bankWriteData    (bankWriteData),
        .bankReadAddressA (bankReadAddressA),
        .bankReadAddressB (bankReadAddressB),
        .bankReadDataA    (bankReadDataA),
        .bankReadDataB    (bankReadDataB),
        .opValid          (opValid),
        .opReady          (opReady),
        .opA              (opA),
        .opB              (opB),
        .opTag            (opTag)
    );

    always #5 clk = ~clk;

    // Behavioural bank: registered reads that return pre-write data on a same-cycle write.
    logic [DW-1:0] mem [NREG];
    always @(posedge clk) begin
        bankReadDataA <= mem[bankReadAddressA];
        bankReadDataB <= mem[bankReadAddressB];
        if (bankWriteEnable) mem[bankWriteAddress] <= bankWriteData;
    end

    // Reference: architectural register values plus the operand request being presented.
    logic [DW-1:0] arch [NREG];
    logic          mValid = 1'b0;
    logic [AW-1:0] mA = '0;
    logic [AW-1:0] mB = '0;
    logic [TW-1:0] mTag = '0;

    int ncmp = 0;
    int nfail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set(input logic iv, input int sa, input int sb, input int tg,
                       input logic wv, input int wa, input logic [DW-1:0] wd,
                       input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        issueValid = iv;
        issueSrcA  = AW'(sa);
        issueSrcB  = AW'(sb);
        issueTag   = TW'(tg);
        wbValid    = wv;
        wbAddr     = AW'(wa);
        wbData     = wd;
        opReady    = ordy;
        flush      = fl;
    endtask

    task automatic idle(input logic ordy);
        set(1'b0, 0, 0, 0, 1'b0, 0, '0, ordy, 1'b0);
    endtask

    // Compare against the model mid-cycle, then advance the model with this cycle's inputs.
    task automatic tick();
        logic acc;
        @(negedge clk);
        check("opValid", {63'b0, opValid}, {63'b0, mValid});
        check("issueReady", {63'b0, issueReady}, {63'b0, (!mValid || opReady)});
        check("bankWriteEnable", {63'b0, bankWriteEnable}, {63'b0, (wbValid && wbAddr != 0)});
        if (mValid) begin
            check("opA", 64'(opA), 64'(arch[mA]));
            check("opB", 64'(opB), 64'(arch[mB]));
            check("opTag", 64'(opTag), 64'(mTag));
        end
        acc = issueValid && (!mValid || opReady) && !flush;
        if (flush) mValid = 1'b0;
        else if (acc) mValid = 1'b1;
        else if (mValid && opReady) mValid = 1'b0;
        if (acc) begin
            mA = issueSrcA;
            mB = issueSrcB;
            mTag = issueTag;
        end
        if (wbValid && wbAddr != 0) arch[wbAddr] = wbData;
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            mem[i]  = $urandom;
            arch[i] = mem[i];
        end
        mem[0]  = 32'h5A5A_5A5A;
        arch[0] = '0;
        mem[3] = 32'h11; arch[3] = 32'h11;
        mem[4] = 32'h22; arch[4] = 32'h22;
        mem[5] = 32'h55; arch[5] = 32'h55;
        mem[6] = 32'h66; arch[6] = 32'h66;

        #12;
        check("reset opValid", {63'b0, opValid}, 64'd0);
        check("reset opTag", 64'(opTag), 64'd0);
        check("reset opA", 64'(opA), 64'd0);
        check("reset issueReady", {63'b0, issueReady}, 64'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // Plain read of preloaded registers.
        set(1'b1, 3, 4, 8'h31, 1'b0, 0, '0, 1'b1, 1'b0); tick();
        idle(1'b1); tick();
        check("t1 opA", 64'(opA), 64'h11);
        check("t1 opB", 64'(opB), 64'h22);
        check("t1 issueReady", {63'b0, issueReady}, 64'd1);

        // Same-cycle writeback must be bypassed.
        set(1'b1, 5, 4, 8'h52, 1'b1, 5, 32'hDEAD, 1'b1, 1'b0); tick();
        idle(1'b1); tick();
        check("t2 bypass opA", 64'(opA), 64'hDEAD);

        // Stall with a write landing in the second stall cycle.
        set(1'b1, 6, 3, 8'h66, 1'b0, 0, '0, 1'b0, 1'b0); tick();
        idle(1'b0); tick();
        check("t3 stall1 opA", 64'(opA), 64'h66);
        check("t3 stall1 issueReady", {63'b0, issueReady}, 64'd0);
        set(1'b0, 0, 0, 0, 1'b1, 6, 32'hBEEF, 1'b0, 1'b0); tick();
        check("t3 stall2 opA", 64'(opA), 64'h66);
        idle(1'b0); tick();
        check("t3 stall3 opA", 64'(opA), 64'hBEEF);
        check("t3 stall3 opTag", 64'(opTag), 64'h66);
        idle(1'b1); tick();

        // Register zero ignores writes and reads as zero.
        set(1'b0, 0, 0, 0, 1'b1, 0, 32'hFFFF, 1'b1, 1'b0); tick();
        check("t4 bankWriteEnable", {63'b0, bankWriteEnable}, 64'd0);
        set(1'b1, 0, 0, 8'h00, 1'b0, 0, '0, 1'b1, 1'b0); tick();
        idle(1'b1); tick();
        check("t4 opA", 64'(opA), 64'd0);
        check("t4 opB", 64'(opB), 64'd0);

        // Back-to-back writes: newest wins.
        set(1'b0, 0, 0, 0, 1'b1, 7, 32'h1, 1'b1, 1'b0); tick();
        set(1'b1, 3, 7, 8'h77, 1'b1, 7, 32'h2, 1'b1, 1'b0); tick();
        idle(1'b1); tick();
        check("t5 opB", 64'(opB), 64'h2);

        // Flush on a stalled request beats a same-cycle issue.
        set(1'b1, 3, 4, 8'hA1, 1'b0, 0, '0, 1'b0, 1'b0); tick();
        set(1'b1, 5, 6, 8'hA2, 1'b0, 0, '0, 1'b0, 1'b1); tick();
        idle(1'b0); tick();
        check("t6 flush opValid", {63'b0, opValid}, 64'd0);

        // Asynchronous reset in the middle of a stall.
        set(1'b1, 4, 3, 8'hB1, 1'b0, 0, '0, 1'b0, 1'b0); tick();
        idle(1'b0); tick();
        #2;
        reset_n = 1'b0;
        #1;
        check("t6 async reset opValid", {63'b0, opValid}, 64'd0);
        mValid = 1'b0; mA = '0; mB = '0; mTag = '0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Random traffic on a small register window to exercise bypass and stalls.
        for (int n = 0; n < 3000; n++) begin
            set(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/regfile_operand_fetch.md
Name: regfile_operand_fetch

Overview:
- Operand-fetch stage that sits directly in front of the dual-read-port register-file bank.
- Accepts issue requests: two source addresses plus a sideband tag. Drives the bank read addresses and forwards the writeback stream to the bank write port.
- Bypasses in-flight writes so presented operands never show stale data from the bank's registered read path.
- Presents operands to execute through a valid/ready handshake with stall-safe refresh.

Parameters:
- DATA_WIDTH, 32, register/operand width.
- ADDR_WIDTH, 5, register address width (2^ADDR_WIDTH registers).
- TAG_WIDTH, 8, opaque sideband carried from issue to operand output.
- ZERO_REG, 1, when 1 register 0 always reads as 0 and writes to it are dropped.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- issueValid  in  1  issue request present.
- issueReady  out  1  stage can accept a request this cycle.
- issueSrcA  in  ADDR_WIDTH  source register A.
- issueSrcB  in  ADDR_WIDTH  source register B.
- issueTag  in  TAG_WIDTH  sideband.
- flush  in  1  discard held request.
- wbValid  in  1  writeback valid.
- wbAddr  in  ADDR_WIDTH  writeback register.
- wbData  in  DATA_WIDTH  writeback data.
- bankWriteEnable  out  1  to bank write enable.
- bankWriteAddress  out  ADDR_WIDTH  to bank write address.
- bankWriteData  out  DATA_WIDTH  to bank write data.
- bankReadAddressA  out  ADDR_WIDTH  to bank read port A.
- bankReadAddressB  out  ADDR_WIDTH  to bank read port B.
- bankReadDataA  in  DATA_WIDTH  bank port A data; registered, valid 1 cycle after address, old data on same-cycle write.
- bankReadDataB  in  DATA_WIDTH  bank port B data; same timing as port A.
- opValid  out  1  operands valid.
- opReady  in  1  execute accepts operands.
- opA  out  DATA_WIDTH  operand A.
- opB  out  DATA_WIDTH  operand B.
- opTag  out  TAG_WIDTH  carried tag.

Behaviour:
- Reset (async assert, sync deassert by the top-level reset synchroniser): opValid=0; held srcA/srcB/tag=0; bypass flags=0; bypass data=0. Combinational outputs take values derived from these registers.
- issueReady = !opValid || opReady (one-deep stage, full throughput). Accept when issueValid && issueReady.
- Read-address mux:
  - Accepting: bank read addresses = issueSrcA/B.
  - Otherwise: bank read addresses = held srcA/B. This re-reads every stalled cycle so operands stay live.
- Bypass capture, every cycle, per port X:
  - bypX <= bankWriteEnable && bankWriteAddress==readAddressX (this cycle's read address).
  - bypDataX <= wbData.
- Operand output in cycle C:
  - opX = 0 if ZERO_REG && heldSrcX==0.
  - Else bypDataX if bypX.
  - Else bankReadDataX.
- Guarantee: the operand presented in cycle C reflects every write with bankWriteEnable asserted in any cycle ≤ C-1.
- Latency: request accepted in cycle T gives opValid in T+1.
- Write path, combinational pass-through:
  - bankWriteEnable = wbValid && !(ZERO_REG && wbAddr==0).
  - bankWriteAddress = wbAddr; bankWriteData = wbData.
- opValid next state:
  - flush: 0, with priority over everything. Any issue in the same cycle is dropped and issueReady is unaffected.
  - else accept: 1.
  - else opValid && opReady: 0.
  - else hold.
- Held srcA/srcB/tag load only on accept.
- Stall (opValid && !opReady): opA/opB may change as new writebacks land; opTag stays stable.
- srcA==srcB: both ports bypass identically; no special case.
- Back-to-back writes to the same register: the most recent write (cycle C-1) wins through the bypass. The older write is already in the bank by then.
- No X propagation on opA/opB when opValid=0; values are don't-care but deterministic.

Decomposition:
- Package regfile_pkg:
  - regAddr_t, regData_t, regTag_t typedefs.
  - ZERO_REG_ADDR constant.
  - Packed struct operandReq_t {srcA, srcB, tag}.
- Sub-module operand_bypass: instantiated once per read port.
  - Contains the read-address mux, the bypass compare/capture registers and the output select.
  - Top module holds the handshake/valid state and the write pass-through.

Test Plan:
- Reset then issue srcA=3, srcB=4 with bank preloaded r3=0x11, r4=0x22 -> opValid in next cycle; opA=0x11, opB=0x22; issueReady stays 1 with opReady=1.
- wbValid wbAddr=5 wbData=0xDEAD in the same cycle as issue srcA=5 -> opA=0xDEAD, via bypass; bank alone would return old value.
- Issue srcA=6, hold opReady=0 three cycles; write r6=0xBEEF in the second stall cycle -> opA switches to 0xBEEF one cycle later; opTag unchanged; issueReady=0 throughout the stall.
- Issue srcA=0, srcB=0 after wbAddr=0 wbData=0xFFFF (ZERO_REG=1) -> bankWriteEnable=0; opA=opB=0.
- Writes to r7 of 0x1 then 0x2 on consecutive cycles, issue srcB=7 with the second write -> opB=0x2.
- Stalled valid request with flush=1 and issueValid=1 in the same cycle -> opValid=0 next cycle; no operand delivered; reset_n low mid-stall forces opValid=0 immediately.
